// File: rtl/conv_window_pkg.sv
// Shared types and width helpers for the horizontal window controller.
package conv_window_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      RPAD,
      DONE
   } state_e;

   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic int x_width(input int max_x, input int pl, input int pr);
      return $clog2(max_x + pl + pr + 1);
   endfunction

   function automatic int win_count(input int len, input int ker, input int stride);
      if (len < ker) return 0;
      return (len - ker) / stride + 1;
   endfunction

endpackage

// File: rtl/conv_window_if.sv
// Streamer/controller/MAC-side bundle of the window controller.
interface conv_window_if #(
   parameter int KER_SIZE  = 3,
   parameter int PAD_L     = 1,
   parameter int PAD_R     = 1,
   parameter int NUM_CH    = 1,
   parameter int MAX_X_DIM = 256
) ();
   localparam int XW = conv_window_pkg::x_width(MAX_X_DIM, PAD_L, PAD_R);
   localparam int KW = conv_window_pkg::clog2_min1(KER_SIZE);
   localparam int CW = conv_window_pkg::clog2_min1(NUM_CH);

   logic                start;
   logic [XW-1:0]       cfg_x_dim;
   logic                in_valid;
   logic                in_ready;
   logic                wr_en;
   logic [KW-1:0]       col_ptr;
   logic [CW-1:0]       ch_idx;
   logic                pad_valid;
   logic                win_valid;
   logic [XW-1:0]       win_start;
   logic [KER_SIZE-1:0] left_pad_mask;
   logic [KER_SIZE-1:0] right_pad_mask;
   logic                row_done;
   logic                busy;
   logic                cfg_err;

   modport master (
      output start, cfg_x_dim, in_valid,
      input  in_ready, wr_en, col_ptr, ch_idx, pad_valid,
      input  win_valid, win_start, left_pad_mask, right_pad_mask,
      input  row_done, busy, cfg_err
   );

   modport slave (
      input  start, cfg_x_dim, in_valid,
      output in_ready, wr_en, col_ptr, ch_idx, pad_valid,
      output win_valid, win_start, left_pad_mask, right_pad_mask,
      output row_done, busy, cfg_err
   );

endinterface

// File: rtl/conv_window_ctrl_pad_mask_gen.sv
// Maps a window start to per-column left/right pad masks.
module pad_mask_gen #(
   parameter int KER_SIZE = 3,
   parameter int XW       = 9
) (
   input  logic [XW-1:0]       s_i,
   input  logic [XW-1:0]       x_i,
   input  logic [XW-1:0]       pad_l_i,
   output logic [KER_SIZE-1:0] left_o,
   output logic [KER_SIZE-1:0] right_o
);
   logic [XW:0] pos;
   logic [XW:0] rlim;

   always_comb begin
      left_o  = '0;
      right_o = '0;
      pos     = '0;
      rlim    = {1'b0, pad_l_i} + {1'b0, x_i};
      for (int i = 0; i < KER_SIZE; i++) begin
         pos        = {1'b0, s_i} + (XW+1)'(i);
         left_o[i]  = pos < {1'b0, pad_l_i};
         right_o[i] = pos >= rlim;
      end
   end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequences one padded row through a KER_SIZE-column circular line buffer.
// Emits write/pad strobes and strided window descriptors with pad masks.
module conv_window_ctrl #(
   parameter int KER_SIZE  = 3,
   parameter int PAD_L     = 1,
   parameter int PAD_R     = 1,
   parameter int STRIDE    = 1,
   parameter int NUM_CH    = 1,
   parameter int MAX_X_DIM = 256
) (
   input logic clk,
   input logic rst,
   conv_window_if.slave bus
);
   import conv_window_pkg::*;

   localparam int XW = x_width(MAX_X_DIM, PAD_L, PAD_R);
   localparam int KW = clog2_min1(KER_SIZE);
   localparam int CW = clog2_min1(NUM_CH);
   localparam int SW = clog2_min1(STRIDE);

   localparam logic [KW-1:0] COL0     = KW'(PAD_L % KER_SIZE);
   localparam logic [KW-1:0] COL_LAST = KW'(KER_SIZE - 1);
   localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);
   localparam logic [SW-1:0] PH_LAST  = SW'(STRIDE - 1);
   localparam logic [XW-1:0] PL       = XW'(PAD_L);
   localparam logic [XW-1:0] PR       = XW'(PAD_R);
   localparam logic [XW-1:0] K1       = XW'(KER_SIZE - 1);
   localparam logic [XW:0]   MAXX     = (XW+1)'(MAX_X_DIM);
   localparam logic [XW:0]   KEXT     = (XW+1)'(KER_SIZE);
   localparam logic [XW:0]   PADS     = (XW+1)'(PAD_L + PAD_R);

   state_e              state_q, state_d;
   logic [XW-1:0]       x_q, x_d;
   logic [XW-1:0]       p_q, p_d;
   logic [KW-1:0]       col_q, col_d;
   logic [CW-1:0]       ch_q, ch_d;
   logic [SW-1:0]       ph_q, ph_d;
   logic                win_v_q;
   logic [XW-1:0]       win_s_q;
   logic                row_done_q;
   logic                cfg_err_q;

   logic [XW:0]         x_ext, len_ext;
   logic                cfg_ok, accept, reject;
   logic                wr, comp, in_range, win_fire;
   logic [XW-1:0]       last_data, last_pos;
   logic [KW-1:0]       col_inc;
   logic [KER_SIZE-1:0] lm_raw, rm_raw;

   assign x_ext   = {1'b0, bus.cfg_x_dim};
   assign len_ext = x_ext + PADS;
   assign cfg_ok  = (x_ext != '0) && (x_ext <= MAXX) && (len_ext >= KEXT);
   assign accept  = (state_q == IDLE) && bus.start && cfg_ok;
   assign reject  = (state_q == IDLE) && bus.start && !cfg_ok;

   assign wr        = (state_q == RUN) && bus.in_valid;
   assign last_data = PL + x_q - 1'b1;
   assign last_pos  = last_data + PR;
   assign col_inc   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;

   // A column completes on its last channel beat, or on its pad cycle.
   assign comp     = (wr && (ch_q == CH_LAST)) || (state_q == RPAD);
   assign in_range = comp && (p_q >= K1);
   assign win_fire = in_range && (ph_q == '0);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      p_d     = p_q;
      col_d   = col_q;
      ch_d    = ch_q;
      ph_d    = ph_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = RUN;
               x_d     = bus.cfg_x_dim;
               p_d     = PL;
               col_d   = COL0;
               ch_d    = '0;
               ph_d    = '0;
            end
         end
         RUN: begin
            if (wr) begin
               if (ch_q == CH_LAST) begin
                  ch_d  = '0;
                  col_d = col_inc;
                  p_d   = p_q + 1'b1;
                  if (p_q == last_data) begin
                     state_d = (PAD_R > 0) ? RPAD : DONE;
                  end
               end else begin
                  ch_d = ch_q + 1'b1;
               end
            end
         end
         RPAD: begin
            col_d = col_inc;
            p_d   = p_q + 1'b1;
            if (p_q == last_pos) state_d = DONE;
         end
         DONE: begin
            col_d   = COL0;
            state_d = IDLE;
         end
      endcase
      if (in_range) begin
         ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         x_q        <= '0;
         p_q        <= '0;
         col_q      <= COL0;
         ch_q       <= '0;
         ph_q       <= '0;
         win_v_q    <= 1'b0;
         win_s_q    <= '0;
         row_done_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         p_q        <= p_d;
         col_q      <= col_d;
         ch_q       <= ch_d;
         ph_q       <= ph_d;
         win_v_q    <= win_fire;
         win_s_q    <= win_fire ? (p_q - K1) : '0;
         row_done_q <= (state_q == DONE);
         cfg_err_q  <= reject;
      end
   end

   pad_mask_gen #(
      .KER_SIZE(KER_SIZE),
      .XW      (XW)
   ) u_mask (
      .s_i    (win_s_q),
      .x_i    (x_q),
      .pad_l_i(PL),
      .left_o (lm_raw),
      .right_o(rm_raw)
   );

   assign bus.in_ready       = (state_q == RUN);
   assign bus.wr_en          = wr;
   assign bus.col_ptr        = col_q;
   assign bus.ch_idx         = ch_q;
   assign bus.pad_valid      = (state_q == RPAD);
   assign bus.win_valid      = win_v_q;
   assign bus.win_start      = win_s_q;
   assign bus.left_pad_mask  = win_v_q ? lm_raw : '0;
   assign bus.right_pad_mask = win_v_q ? rm_raw : '0;
   assign bus.row_done       = row_done_q;
   assign bus.busy           = (state_q != IDLE);
   assign bus.cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl across four parameter sets.
module tb_conv_window_ctrl;
   import conv_window_pkg::*;

   typedef struct {
      int s;
      int lm;
      int rm;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int         sel = 0;
   logic       start_r = 1'b0;
   logic       vld_r = 1'b0;
   logic [8:0] x_r = '0;

   int checks = 0;
   int failures = 0;
   exp_t expq[$];
   int k_e = 3, nch_e = 1, col0_e = 1, pads_e = 1, cnt_e = 3;

   conv_window_if #(.KER_SIZE(3)) if0 ();
   conv_window_if #(.KER_SIZE(3)) if1 ();
   conv_window_if #(.KER_SIZE(3), .NUM_CH(4)) if2 ();
   conv_window_if #(.KER_SIZE(5), .PAD_L(2), .PAD_R(0)) if3 ();

   conv_window_ctrl #(.KER_SIZE(3)) u0 (.clk(clk), .rst(rst), .bus(if0));
   conv_window_ctrl #(.KER_SIZE(3), .STRIDE(2)) u1 (.clk(clk), .rst(rst), .bus(if1));
   conv_window_ctrl #(.KER_SIZE(3), .NUM_CH(4)) u2 (.clk(clk), .rst(rst), .bus(if2));
   conv_window_ctrl #(.KER_SIZE(5), .PAD_L(2), .PAD_R(0)) u3 (.clk(clk), .rst(rst), .bus(if3));

   assign if0.start = start_r && (sel == 0);
   assign if1.start = start_r && (sel == 1);
   assign if2.start = start_r && (sel == 2);
   assign if3.start = start_r && (sel == 3);
   assign if0.in_valid = vld_r && (sel == 0);
   assign if1.in_valid = vld_r && (sel == 1);
   assign if2.in_valid = vld_r && (sel == 2);
   assign if3.in_valid = vld_r && (sel == 3);
   assign if0.cfg_x_dim = x_r;
   assign if1.cfg_x_dim = x_r;
   assign if2.cfg_x_dim = x_r;
   assign if3.cfg_x_dim = x_r;

   logic [31:0] m_wv, m_ws, m_lm, m_rm, m_rd, m_pv;
   logic [31:0] m_busy, m_err, m_rdy, m_wr, m_col, m_ch;

`define TB_PICK(IF) begin \
   m_wv = 32'(IF.win_valid); m_ws = 32'(IF.win_start); \
   m_lm = 32'(IF.left_pad_mask); m_rm = 32'(IF.right_pad_mask); \
   m_rd = 32'(IF.row_done); m_pv = 32'(IF.pad_valid); \
   m_busy = 32'(IF.busy); m_err = 32'(IF.cfg_err); \
   m_rdy = 32'(IF.in_ready); m_wr = 32'(IF.wr_en); \
   m_col = 32'(IF.col_ptr); m_ch = 32'(IF.ch_idx); end

   always_comb begin
      case (sel)
         0:       `TB_PICK(if0)
         1:       `TB_PICK(if1)
         2:       `TB_PICK(if2)
         default: `TB_PICK(if3)
      endcase
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0d exp=%0d (t=%0t)", n, act, exp, $time);
      end
   endtask

   // Monitor: pops expected windows and tracks a column/channel model.
   int wins = 0, pads = 0, mdl_ch = 0, mdl_col = 0;
   logic [31:0] prev_rd = '0;
   exp_t e;
   always @(negedge clk) begin
      if (rst) begin
         wins = 0;
         pads = 0;
         prev_rd = '0;
      end else begin
         chk("wr_en", m_wr, m_rdy & {31'b0, vld_r});
         if (m_wv != 0) begin
            wins++;
            if (expq.size() == 0) begin
               chk("win_extra", m_wv, 0);
            end else begin
               e = expq.pop_front();
               chk("win_start", m_ws, e.s);
               chk("left_mask", m_lm, e.lm);
               chk("right_mask", m_rm, e.rm);
            end
         end else begin
            chk("idle_zero", m_ws | m_lm | m_rm, 0);
         end
         if (m_busy == 0) begin
            mdl_ch = 0;
            mdl_col = col0_e;
         end
         if (m_wr != 0) begin
            chk("ch_idx", m_ch, mdl_ch);
            chk("col_ptr_wr", m_col, mdl_col);
            if (mdl_ch == nch_e - 1) begin
               mdl_ch = 0;
               mdl_col = (mdl_col + 1) % k_e;
            end else begin
               mdl_ch++;
            end
         end
         if (m_pv != 0) begin
            chk("col_ptr_pad", m_col, mdl_col);
            mdl_col = (mdl_col + 1) % k_e;
            pads++;
         end
         if (m_rd != 0) begin
            chk("rd_pulse", prev_rd, 0);
            chk("win_count", wins, cnt_e);
            chk("pad_count", pads, pads_e);
            chk("win_missing", expq.size(), 0);
            wins = 0;
            pads = 0;
         end
         prev_rd = m_rd;
      end
   end

   task automatic push(input int s, input int lm, input int rm);
      expq.push_back('{s: s, lm: lm, rm: rm});
   endtask

   task automatic setup(input int sl, input int k, input int nch, input int c0,
                        input int pd, input int cnt);
      sel = sl;
      k_e = k;
      nch_e = nch;
      col0_e = c0;
      pads_e = pd;
      cnt_e = cnt;
   endtask

   task automatic run_row(input int x, input bit tog);
      int n;
      x_r = 9'(x);
      start_r = 1'b1;
      @(posedge clk); #1;
      start_r = 1'b0;
      n = 0;
      while (m_rd == 0 && n < 400) begin
         vld_r = tog ? n[0] : 1'b1;
         @(posedge clk); #1;
         n++;
      end
      vld_r = 1'b0;
      chk("row_timeout", {31'b0, n < 400}, 1);
      @(posedge clk); #1;
   endtask

   task automatic chk_reset(input int c0);
      chk("rst_ready", m_rdy, 0);
      chk("rst_wr", m_wr, 0);
      chk("rst_pad", m_pv, 0);
      chk("rst_win", m_wv, 0);
      chk("rst_done", m_rd, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_err", m_err, 0);
      chk("rst_masks", m_lm | m_rm, 0);
      chk("rst_wstart", m_ws, 0);
      chk("rst_ch", m_ch, 0);
      chk("rst_col", m_col, c0);
   endtask

   task automatic bad_start(input int x);
      x_r = 9'(x);
      start_r = 1'b1;
      @(posedge clk); #1;
      start_r = 1'b0;
      chk("cfg_err_hi", m_err, 1);
      chk("cfg_busy", m_busy, 0);
      @(posedge clk); #1;
      chk("cfg_err_lo", m_err, 0);
      chk("cfg_busy2", m_busy, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_reset(1);
      rst = 1'b0;
      @(posedge clk); #1;

      setup(0, 3, 1, 1, 1, win_count(5, 3, 1));
      push(0, 'b001, 0); push(1, 0, 0); push(2, 0, 'b100);
      run_row(3, 1'b0);

      setup(1, 3, 1, 1, 1, win_count(8, 3, 2));
      push(0, 'b001, 0); push(2, 0, 0); push(4, 0, 0);
      run_row(6, 1'b0);

      setup(2, 3, 4, 1, 1, win_count(5, 3, 1));
      push(0, 'b001, 0); push(1, 0, 0); push(2, 0, 'b100);
      run_row(3, 1'b1);

      setup(3, 5, 1, 2, 0, win_count(6, 5, 1));
      push(0, 'b00011, 0); push(1, 'b00001, 0);
      run_row(4, 1'b0);

      setup(0, 3, 1, 1, 1, 0);
      bad_start(0);
      bad_start(257);

      setup(2, 3, 4, 1, 1, win_count(5, 3, 1));
      x_r = 9'd3;
      start_r = 1'b1;
      @(posedge clk); #1;
      start_r = 1'b0;
      vld_r = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_ch", m_ch, 2);
      rst = 1'b1;
      vld_r = 1'b0;
      @(posedge clk); #1;
      chk_reset(1);
      rst = 1'b0;
      @(posedge clk); #1;
      push(0, 'b001, 0); push(1, 0, 0); push(2, 0, 'b100);
      run_row(3, 1'b0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Parametrised successor to the single-row line-buffer column controller. Sequences one padded input row through a KER_SIZE-column circular line buffer.
- Adds runtime row width, independent left/right padding, horizontal stride, multi-channel beats, a valid/ready input handshake and config error detection.
- Sits between the activation streamer and the line buffer. Drives write column/channel, pad-column injection, per-window pad masks and window-valid to the MAC array.

Parameters:
- KER_SIZE, 3: kernel width in columns; circular buffer depth.
- PAD_L, 1: left zero-pad columns, 0..KER_SIZE-1.
- PAD_R, 1: right zero-pad columns, 0..KER_SIZE-1.
- STRIDE, 1: horizontal window stride, >=1.
- NUM_CH, 1: channel beats per column.
- MAX_X_DIM, 256: maximum runtime row width.
- Derived: XW=$clog2(MAX_X_DIM+PAD_L+PAD_R+1), KW=max(1,$clog2(KER_SIZE)), CW=max(1,$clog2(NUM_CH)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a row; sampled only in IDLE.
- cfg_x_dim  in  XW  unpadded row width; latched on an accepted start.
- in_valid  in  1  input beat valid.
- in_ready  out  1  controller accepts a beat.
- wr_en  out  1  line-buffer write strobe; equals in_valid&&in_ready.
- col_ptr  out  KW  buffer column for the current write or pad column.
- ch_idx  out  CW  channel of the current beat.
- pad_valid  out  1  right-pad column injection cycle.
- win_valid  out  1  a complete window is available.
- win_start  out  XW  padded start position of the window.
- left_pad_mask  out  KER_SIZE  bit i = window column i is left padding.
- right_pad_mask  out  KER_SIZE  bit i = window column i is right padding.
- row_done  out  1  one-cycle end-of-row pulse.
- busy  out  1  state != IDLE.
- cfg_err  out  1  one-cycle pulse on a rejected start.

Behaviour:
- Reset (synchronous, applies at any point including mid-row): state IDLE; in_ready, wr_en, pad_valid, win_valid, row_done, busy, cfg_err = 0; masks = 0; win_start = 0; ch_idx = 0; col_ptr = PAD_L mod KER_SIZE.
- Padded position p runs 0..L-1, where L = PAD_L+X+PAD_R. Column p occupies slot p mod KER_SIZE. Left-pad columns are virtual: never written, never cycled.
- States: IDLE, RUN, RPAD, DONE.
- IDLE→RUN on start when 1<=X<=MAX_X_DIM and L>=KER_SIZE. A start that violates this pulses cfg_err next cycle and stays in IDLE.
- RUN: in_ready=1. Each accepted beat increments ch_idx. On the beat with ch_idx=NUM_CH-1: ch_idx←0, col_ptr advances (wrap KER_SIZE-1→0), p increments.
- Stalls (in_valid=0) hold all counters.
- After the last data column: go to RPAD if PAD_R>0, otherwise DONE.
- RPAD: in_ready=0, wr_en=0, pad_valid=1 for exactly PAD_R cycles, one per pad column. col_ptr and p advance each cycle. Then go to DONE.
- DONE: row_done=1 for one cycle, col_ptr←PAD_L mod KER_SIZE, then go to IDLE. A new start is accepted the cycle after DONE at the earliest.
- Window rule: when position p completes with p>=KER_SIZE-1 and s=p-(KER_SIZE-1) satisfies s mod STRIDE==0, assert the following on the next cycle for one cycle:
  - win_valid=1 and win_start=s.
  - left_pad_mask[i] = (s+i < PAD_L).
  - right_pad_mask[i] = (s+i >= PAD_L+X).
- "Completes" means the last-channel beat is accepted (RUN) or its pad cycle occurs (RPAD).
- Masks and win_start are 0 whenever win_valid=0.
- Window count per row is exactly floor((L-KER_SIZE)/STRIDE)+1.
- Position and width arithmetic is unsigned, XW bits. cfg_x_dim is ignored outside IDLE.

Decomposition:
- Package conv_window_pkg: state enum (IDLE, RUN, RPAD, DONE), clog2-based width helper functions, and a pure function computing the window count from L, KER_SIZE and STRIDE.
- One sub-module, pad_mask_gen: combinational. Maps s, X, PAD_L to both KER_SIZE-bit masks. Shared with the future vertical controller.

Test Plan:
- Defaults, X=3, no stalls → 3 windows. win_start 0,1,2. Left masks 001,000,000; right masks 000,000,100. pad_valid high 1 cycle. row_done after the last window.
- STRIDE=2, X=6 → 3 windows at s=0,2,4. Left masks 001,000,000; right masks all 000. Positions 1,3 produce no win_valid.
- NUM_CH=4, X=3, in_valid toggling 50% → ch_idx cycles 0..3. col_ptr advances only on ch 3. Window outputs match the first scenario (win_start, masks, count).
- KER_SIZE=5, PAD_L=2, PAD_R=0, X=4 → windows s=0,1 with left masks 00011, 00001. pad_valid never asserts. row_done the cycle after the second window.
- start with cfg_x_dim=0 → cfg_err pulse 1 cycle, busy stays 0. Repeat with X=MAX_X_DIM+1 → same response.
- rst asserted in RUN mid-column → next cycle all outputs at reset values. A following start runs a clean row identical to the first scenario.
